// File: rtl/booth_mac_acc_if.sv
// Product-in / result-out handshake bundle for booth_mac_acc.
// master = upstream multiplier plus downstream consumer; slave = accumulator.
interface booth_mac_acc_if #(
  parameter int BW    = 4,
  parameter int ACC_W = 16
);
  logic                      prod_valid;
  logic                      prod_ready;
  logic signed [2*BW-1:0]    prod_data;
  logic                      prod_last;
  logic                      acc_valid;
  logic                      acc_ready;
  logic signed [ACC_W-1:0]   acc_data;
  logic                      acc_ovf;

  modport master (
    output prod_valid, prod_data, prod_last, acc_ready,
    input  prod_ready, acc_valid, acc_data, acc_ovf
  );

  modport slave (
    input  prod_valid, prod_data, prod_last, acc_ready,
    output prod_ready, acc_valid, acc_data, acc_ovf
  );
endinterface

// File: rtl/booth_mac_acc.sv
// Signed burst accumulator behind the Booth multiplier: sums up to LEN products per burst.
// Define SATURATE_EN to clamp the accumulator on overflow instead of wrapping.
module booth_mac_acc #(
  parameter int BW    = 4,
  parameter int ACC_W = 16,
  parameter int LEN   = 8
) (
  input  logic          clk,
  input  logic          rst,
  booth_mac_acc_if.slave bus
);

  localparam int CW = $clog2(LEN + 1);
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  if (ACC_W < 2*BW) begin : g_acc_w_check
    $error("booth_mac_acc: ACC_W must be >= 2*BW");
  end
  if (LEN < 1) begin : g_len_check
    $error("booth_mac_acc: LEN must be >= 1");
  end

  typedef enum logic {ACCUM, DONE} state_t;

  state_t                  state, state_nxt;
  logic signed [ACC_W-1:0] acc_p0, acc_nxt;
  logic [CW-1:0]           cnt_p0, cnt_nxt;
  logic                    ovf_p0, ovf_nxt;

  logic                    accept;
  logic                    add_ovf;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] sum_raw;
  logic signed [ACC_W-1:0] acc_sum;

  // Same-sign addends whose raw sum flips sign have left the signed range.
  function automatic logic ovf_detect(
    input logic signed [ACC_W-1:0] a,
    input logic signed [ACC_W-1:0] b,
    input logic signed [ACC_W-1:0] s
  );
    return (a[ACC_W-1] == b[ACC_W-1]) && (s[ACC_W-1] != a[ACC_W-1]);
  endfunction

`ifdef SATURATE_EN
  function automatic logic signed [ACC_W-1:0] saturate(
    input logic signed [ACC_W-1:0] a,
    input logic signed [ACC_W-1:0] s,
    input logic                    ovf
  );
    if (ovf) return a[ACC_W-1] ? ACC_MIN : ACC_MAX;
    return s;
  endfunction
`endif

  assign prod_ext = ACC_W'(bus.prod_data);
  assign sum_raw  = acc_p0 + prod_ext;
  assign add_ovf  = ovf_detect(acc_p0, prod_ext, sum_raw);

`ifdef SATURATE_EN
  assign acc_sum = saturate(acc_p0, sum_raw, add_ovf);
`else
  assign acc_sum = sum_raw;
`endif

  assign bus.prod_ready = (state == ACCUM) && !rst;
  assign accept         = bus.prod_valid && bus.prod_ready;

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc_p0;
    cnt_nxt   = cnt_p0;
    ovf_nxt   = ovf_p0;
    case (state)
      ACCUM: begin
        if (accept) begin
          acc_nxt = acc_sum;
          cnt_nxt = cnt_p0 + CW'(1);
          ovf_nxt = ovf_p0 | add_ovf;
          if (bus.prod_last || (cnt_p0 == CW'(LEN - 1))) state_nxt = DONE;
        end
      end
      DONE: begin
        if (bus.acc_ready) begin
          acc_nxt   = '0;
          cnt_nxt   = '0;
          ovf_nxt   = 1'b0;
          state_nxt = ACCUM;
        end
      end
      default: state_nxt = ACCUM;
    endcase
  end

  // Stage p0: accumulator, beat counter and sticky flag; all cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ACCUM;
      acc_p0 <= '0;
      cnt_p0 <= '0;
      ovf_p0 <= 1'b0;
    end else begin
      state  <= state_nxt;
      acc_p0 <= acc_nxt;
      cnt_p0 <= cnt_nxt;
      ovf_p0 <= ovf_nxt;
    end
  end

  assign bus.acc_valid = (state == DONE);
  assign bus.acc_data  = acc_p0;
  assign bus.acc_ovf   = ovf_p0;

endmodule

// File: tb/tb_booth_mac_acc.sv
// Bench for booth_mac_acc: directed burst table and corner sequences on a 16-bit
// accumulator, plus saturation/wrap and randomized bursts on an 8-bit accumulator.
module tb_booth_mac_acc;

  localparam int BW  = 4;
  localparam int LEN = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  booth_mac_acc_if #(.BW(BW), .ACC_W(16)) b16 ();
  booth_mac_acc_if #(.BW(BW), .ACC_W(8))  b8 ();

  booth_mac_acc #(.BW(BW), .ACC_W(16), .LEN(LEN)) dut16 (
    .clk(clk), .rst(rst), .bus(b16.slave)
  );
  booth_mac_acc #(.BW(BW), .ACC_W(8), .LEN(LEN)) dut8 (
    .clk(clk), .rst(rst), .bus(b8.slave)
  );

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    int              n;
    bit              last;
    logic [3:0][7:0] p;
    int              exp;
    bit              ovf;
  } vec_t;

  function automatic vec_t mk(input int n, input bit last, input int a, input int b,
                              input int c, input int d, input int exp, input bit ovf);
    vec_t v;
    v.n    = n;
    v.last = last;
    v.p    = {8'(d), 8'(c), 8'(b), 8'(a)};
    v.exp  = exp;
    v.ovf  = ovf;
    return v;
  endfunction

  task automatic chk(input string name, input logic signed [31:0] act,
                     input logic signed [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Back-to-back burst on the 16-bit instance with acc_ready held high.
  task automatic run_vec16(input vec_t v, input string tag);
    for (int i = 0; i < v.n; i++) begin
      @(negedge clk);
      chk({tag, "_ready_beat"}, b16.prod_ready, 1);
      b16.prod_valid = 1'b1;
      b16.prod_data  = v.p[i];
      b16.prod_last  = v.last && (i == v.n - 1);
    end
    @(negedge clk);
    b16.prod_valid = 1'b0;
    b16.prod_last  = 1'b0;
    chk({tag, "_valid"}, b16.acc_valid, 1);
    chk({tag, "_data"}, b16.acc_data, v.exp);
    chk({tag, "_ovf"}, b16.acc_ovf, v.ovf);
    chk({tag, "_ready_done"}, b16.prod_ready, 0);
    @(negedge clk);
    chk({tag, "_ready_after"}, b16.prod_ready, 1);
    chk({tag, "_valid_after"}, b16.acc_valid, 0);
  endtask

  task automatic run_b8(input int a, input int b, input int c, input int exp,
                        input bit ovf, input string tag);
    int vals[3];
    vals = '{a, b, c};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      b8.prod_valid = 1'b1;
      b8.prod_data  = 8'(vals[i]);
      b8.prod_last  = (i == 2);
    end
    @(negedge clk);
    b8.prod_valid = 1'b0;
    b8.prod_last  = 1'b0;
    chk({tag, "_valid"}, b8.acc_valid, 1);
    chk({tag, "_data"}, b8.acc_data, exp);
    chk({tag, "_ovf"}, b8.acc_ovf, ovf);
    @(negedge clk);
    chk({tag, "_valid_after"}, b8.acc_valid, 0);
  endtask

  vec_t vecs[7];

  // Reference: running sum in plain integers, clamped or wrapped into 8-bit range.
  int  ref_v   = 0;
  int  ref_k   = 0;
  bit  ref_o   = 1'b0;
  int  exp_d[$];
  bit  exp_o[$];

  task automatic model_beat(input int p, input bit last);
    int t;
    t = ref_v + p;
    if (t > 127 || t < -128) begin
      ref_o = 1'b1;
`ifdef SATURATE_EN
      t = (t > 127) ? 127 : -128;
`else
      t = (t > 127) ? t - 256 : t + 256;
`endif
    end
    ref_v = t;
    ref_k++;
    if (last || ref_k == LEN) begin
      exp_d.push_back(ref_v);
      exp_o.push_back(ref_o);
      ref_v = 0;
      ref_k = 0;
      ref_o = 1'b0;
    end
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int closed, consumed, cyc, r, d, e;
    bit eo;

    vecs[0] = mk(4, 1, -6, 49, -64, 15, -6, 0);
    vecs[1] = mk(2, 1, 10, 20, 0, 0, 30, 0);
    vecs[2] = mk(4, 0, 1, 1, 1, 1, 4, 0);
    vecs[3] = mk(4, 1, -128, -128, -128, -128, -512, 0);
    vecs[4] = mk(1, 1, 127, 0, 0, 0, 127, 0);
    vecs[5] = mk(4, 0, 127, 127, 127, 127, 508, 0);
    vecs[6] = mk(3, 1, -1, 2, -3, 0, -2, 0);

    b16.prod_valid = 1'b0; b16.prod_data = '0; b16.prod_last = 1'b0; b16.acc_ready = 1'b1;
    b8.prod_valid  = 1'b0; b8.prod_data  = '0; b8.prod_last  = 1'b0; b8.acc_ready  = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ready16", b16.prod_ready, 0);
    chk("rst_ready8", b8.prod_ready, 0);
    chk("rst_valid16", b16.acc_valid, 0);
    chk("rst_data16", b16.acc_data, 0);
    chk("rst_ovf16", b16.acc_ovf, 0);
    rst = 1'b0;
    #1;
    chk("rst_release_ready16", b16.prod_ready, 1);

    for (int k = 0; k < 7; k++) run_vec16(vecs[k], $sformatf("vec%0d", k));

    // DONE held for 5 cycles while beats are offered
    b16.acc_ready = 1'b0;
    @(negedge clk);
    b16.prod_valid = 1'b1; b16.prod_data = 8'sd7; b16.prod_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      b16.prod_valid = 1'b1; b16.prod_data = 8'sd100; b16.prod_last = 1'b1;
      chk($sformatf("hold%0d_valid", i), b16.acc_valid, 1);
      chk($sformatf("hold%0d_data", i), b16.acc_data, 7);
      chk($sformatf("hold%0d_ready", i), b16.prod_ready, 0);
    end
    @(negedge clk);
    b16.prod_valid = 1'b0; b16.prod_last = 1'b0; b16.acc_ready = 1'b1;
    chk("hold_last_data", b16.acc_data, 7);
    @(negedge clk);
    chk("hold_consumed_valid", b16.acc_valid, 0);
    chk("hold_consumed_ready", b16.prod_ready, 1);
    chk("hold_cleared_data", b16.acc_data, 0);
    run_vec16(mk(1, 1, 2, 0, 0, 0, 2, 0), "after_hold");

    // Reset mid-burst
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      b16.prod_valid = 1'b1; b16.prod_data = 8'sd5; b16.prod_last = 1'b0;
    end
    @(negedge clk);
    b16.prod_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst_ready_in_rst", b16.prod_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_valid", b16.acc_valid, 0);
    chk("midrst_data", b16.acc_data, 0);
    chk("midrst_ovf", b16.acc_ovf, 0);
    chk("midrst_ready", b16.prod_ready, 1);
    run_vec16(mk(1, 1, 3, 0, 0, 0, 3, 0), "after_midrst");

    // Reset while a result is pending
    b16.acc_ready = 1'b0;
    @(negedge clk);
    b16.prod_valid = 1'b1; b16.prod_data = 8'sd9; b16.prod_last = 1'b1;
    @(negedge clk);
    b16.prod_valid = 1'b0; b16.prod_last = 1'b0;
    chk("donerst_pending", b16.acc_valid, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("donerst_valid", b16.acc_valid, 0);
    chk("donerst_data", b16.acc_data, 0);
    b16.acc_ready = 1'b1;

    // 8-bit accumulator overflow handling
`ifdef SATURATE_EN
    run_b8(64, 64, -1, 126, 1, "sat_pos");
    run_b8(-128, -128, 0, -128, 1, "sat_neg");
`else
    run_b8(64, 64, -1, 127, 1, "wrap_pos");
    run_b8(-128, -128, 0, 0, 1, "wrap_neg");
`endif
    run_b8(100, -50, 27, 77, 0, "b8_no_ovf");

    // Randomized bursts with handshake gaps on the 8-bit instance
    closed = 0; consumed = 0; cyc = 0;
    while (consumed < 1000 && cyc < 60000) begin
      @(negedge clk);
      cyc++;
      b8.prod_valid = (closed < 1000) && ($urandom_range(0, 3) != 0);
      r = $urandom_range(0, 7);
      b8.prod_data  = (r == 0) ? 8'sh7f : (r == 1) ? 8'sh80 : 8'($urandom_range(0, 255));
      b8.prod_last  = ($urandom_range(0, 3) == 0);
      b8.acc_ready  = ($urandom_range(0, 2) != 0);
      if (b8.prod_valid && b8.prod_ready) begin
        model_beat(int'(b8.prod_data), b8.prod_last);
        if (b8.prod_last || ref_k == 0) closed++;
      end
      if (b8.acc_valid && b8.acc_ready) begin
        if (exp_d.size() == 0) begin
          chk("rand_spurious_result", 1, 0);
        end else begin
          e  = exp_d.pop_front();
          eo = exp_o.pop_front();
          d  = int'(b8.acc_data);
          chk($sformatf("rand%0d_data", consumed), d, e);
          chk($sformatf("rand%0d_ovf", consumed), b8.acc_ovf, eo);
        end
        consumed++;
      end
    end
    b8.prod_valid = 1'b0;
    chk("rand_bursts_consumed", consumed, 1000);
    chk("rand_queue_empty", exp_d.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
